stack_unit: RTL and testbench

Pipeline-side responder for the stack and interrupt-return commands that the instruction decoder emits (push, pop, reti), plus the interrupt-entry frame save. It owns the stack pointer and sequences word transactions on the data-memory port. It stalls the pipeline until each sequence completes, then returns popped data or the restored PC and flags. It sits beside the load/store path in the memory stage and shares the data-memory port through an upstream arbiter.

---
 rtl/stack_unit_pkg.sv | 25 ++
 rtl/stack_unit_stack_pointer.sv | 53 +++++
 rtl/stack_unit.sv | 321 ++++++++++++++++++++++++++++++++
 tb/tb_stack_unit.sv | 317 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/stack_unit_pkg.sv
// Shared CPU package: stack FSM state encoding, word stride, flags width and
// default stack-region bounds used by the stack unit and its stack pointer.
package stack_unit_pkg;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_PUSH_WR = 3'd1,
    ST_POP_RD  = 3'd2,
    ST_IRQ_PC  = 3'd3,
    ST_IRQ_FL  = 3'd4,
    ST_RETI_FL = 3'd5,
    ST_RETI_PC = 3'd6
  } state_t;

  // Bytes per stacked word; the stack grows downward by this amount.
  localparam int WORD_STRIDE = 4;

  // Width of the ALU flags saved in an interrupt frame.
  localparam int FLAGS_W = 4;

  // Default empty (top) address and lowest legal (full) address.
  localparam logic [15:0] SP_RESET_DEFAULT = 16'hFFFC;
  localparam logic [15:0] SP_LIMIT_DEFAULT = 16'hF000;

endpackage

// File: rtl/stack_unit_stack_pointer.sv
// Stack pointer register with +/- one-word arithmetic and bounds compares.
// The owner decides when to step; this block only reports empty/full for the
// current value and for the value one push/pop away.
module stack_pointer
  import stack_unit_pkg::*;
#(
  parameter int                ADDR_W   = 16,
  parameter logic [ADDR_W-1:0] SP_RESET = ADDR_W'(SP_RESET_DEFAULT),
  parameter logic [ADDR_W-1:0] SP_LIMIT = ADDR_W'(SP_LIMIT_DEFAULT)
) (
  input  logic              clk,
  input  logic              resetN,
  input  logic              i_dec,
  input  logic              i_inc,
  output logic [ADDR_W-1:0] o_sp,
  output logic [ADDR_W-1:0] o_sp_dec,
  output logic [ADDR_W-1:0] o_sp_inc,
  output logic              o_empty,
  output logic              o_full,
  output logic              o_dec_full,
  output logic              o_inc_empty
);

  localparam logic [ADDR_W-1:0] STRIDE = ADDR_W'(WORD_STRIDE);

  logic [ADDR_W-1:0] r_sp;
  logic [ADDR_W-1:0] w_sp_dec;
  logic [ADDR_W-1:0] w_sp_inc;

  // Arithmetic wraps modulo 2^ADDR_W; bounds policing is the owner's job.
  assign w_sp_dec = r_sp - STRIDE;
  assign w_sp_inc = r_sp + STRIDE;

  // Pointer register: a push step has priority if both are ever requested
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      r_sp <= SP_RESET;
    end else if (i_dec) begin
      r_sp <= w_sp_dec;
    end else if (i_inc) begin
      r_sp <= w_sp_inc;
    end
  end

  assign o_sp        = r_sp;
  assign o_sp_dec    = w_sp_dec;
  assign o_sp_inc    = w_sp_inc;
  assign o_empty     = (r_sp == SP_RESET);
  assign o_full      = (r_sp == SP_LIMIT);
  assign o_dec_full  = (w_sp_dec == SP_LIMIT);
  assign o_inc_empty = (w_sp_inc == SP_RESET);

endmodule

// File: rtl/stack_unit.sv
// Memory-stage responder for push/pop/reti and interrupt-entry frame saves.
// Sequences one or two word transactions on the data-memory port, holds the
// pipeline while busy and returns popped data or the restored PC/flags.
// Optional feature macro: STACK_BOUNDS_CHECK_EN refuses pushes at the stack
// limit and pops at the empty address and raises a sticky stackFault.
module stack_unit
  import stack_unit_pkg::*;
#(
  parameter int                DATA_W   = 32,
  parameter int                ADDR_W   = 16,
  parameter logic [ADDR_W-1:0] SP_RESET = ADDR_W'(SP_RESET_DEFAULT),
  parameter logic [ADDR_W-1:0] SP_LIMIT = ADDR_W'(SP_LIMIT_DEFAULT)
) (
  input  logic               clk,
  input  logic               resetN,
  input  logic               push,
  input  logic               pop,
  input  logic               reti,
  input  logic               irqTake,
  input  logic [DATA_W-1:0]  pushData,
  input  logic [DATA_W-1:0]  irqPc,
  input  logic [FLAGS_W-1:0] flagsIn,
  output logic               memReq,
  output logic               memWe,
  output logic [ADDR_W-1:0]  memAddr,
  output logic [DATA_W-1:0]  memWdata,
  input  logic [DATA_W-1:0]  memRdata,
  input  logic               memAck,
  output logic               stall,
  output logic [DATA_W-1:0]  popData,
  output logic               popValid,
  output logic [DATA_W-1:0]  retiPc,
  output logic [FLAGS_W-1:0] retiFlags,
  output logic               retiValid,
  output logic [ADDR_W-1:0]  sp,
  output logic               stackFault
);

  localparam logic [ADDR_W-1:0] STRIDE = ADDR_W'(WORD_STRIDE);

  state_t              r_state;
  state_t              w_state_next;

  logic                r_mem_req;
  logic                r_mem_we;
  logic [ADDR_W-1:0]   r_mem_addr;
  logic [DATA_W-1:0]   r_mem_wdata;
  logic                w_req_next;
  logic                w_we_next;
  logic [ADDR_W-1:0]   w_addr_next;
  logic [DATA_W-1:0]   w_wdata_next;

  logic [FLAGS_W-1:0]  r_irq_flags;
  logic [FLAGS_W-1:0]  r_reti_flags_tmp;
  logic [DATA_W-1:0]   r_pop_data;
  logic                r_pop_valid;
  logic [DATA_W-1:0]   r_reti_pc;
  logic [FLAGS_W-1:0]  r_reti_flags;
  logic                r_reti_valid;

  logic [ADDR_W-1:0]   w_sp;
  logic [ADDR_W-1:0]   w_sp_dec;
  logic [ADDR_W-1:0]   w_sp_inc;
  logic [ADDR_W-1:0]   w_sp_dec2;
  logic                w_empty;
  logic                w_full;
  logic                w_dec_full;
  logic                w_inc_empty;

  logic                w_sp_dec_en;
  logic                w_sp_inc_en;
  logic                w_word_done;
  logic                w_fault_set;
  logic                w_capture;
  logic                w_pop_done;
  logic                w_flags_load;
  logic                w_reti_done;

  logic                w_refuse_push;
  logic                w_refuse_pop;
  logic                w_refuse_push2;
  logic                w_refuse_pop2;
  logic [DATA_W-1:0]   w_rd_word;

  stack_pointer #(
    .ADDR_W   (ADDR_W),
    .SP_RESET (SP_RESET),
    .SP_LIMIT (SP_LIMIT)
  ) u_stack_pointer (
    .clk         (clk),
    .resetN      (resetN),
    .i_dec       (w_sp_dec_en),
    .i_inc       (w_sp_inc_en),
    .o_sp        (w_sp),
    .o_sp_dec    (w_sp_dec),
    .o_sp_inc    (w_sp_inc),
    .o_empty     (w_empty),
    .o_full      (w_full),
    .o_dec_full  (w_dec_full),
    .o_inc_empty (w_inc_empty)
  );

  // Second frame word of an irq push lands one word below the first.
  assign w_sp_dec2 = w_sp_dec - STRIDE;

  // A word with no request outstanding was refused and finishes at once;
  // an ack with no request outstanding is never looked at.
  assign w_word_done = r_mem_req ? memAck : 1'b1;

  // Refused reads return zero.
  assign w_rd_word = r_mem_req ? memRdata : '0;

`ifdef STACK_BOUNDS_CHECK_EN
  // Second-word checks look at the pointer as it will be after the first
  // word retires (unchanged if the first word itself was refused).
  assign w_refuse_push  = w_full;
  assign w_refuse_pop   = w_empty;
  assign w_refuse_push2 = r_mem_req ? w_dec_full : w_full;
  assign w_refuse_pop2  = r_mem_req ? w_inc_empty : w_empty;

  logic r_fault;

  // Sticky fault: set by any refused word, cleared only by reset
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      r_fault <= 1'b0;
    end else if (w_fault_set) begin
      r_fault <= 1'b1;
    end
  end

  assign stackFault = r_fault;
`else
  assign w_refuse_push  = 1'b0;
  assign w_refuse_pop   = 1'b0;
  assign w_refuse_push2 = 1'b0;
  assign w_refuse_pop2  = 1'b0;
  assign stackFault     = 1'b0;

  logic w_unused_bounds;
  assign w_unused_bounds = ^{w_empty, w_full, w_dec_full, w_inc_empty, w_fault_set};
`endif

  // State register
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Next-state and next memory-port decode; commands accepted by priority
  always_comb begin
    w_state_next = r_state;
    w_req_next   = r_mem_req;
    w_we_next    = r_mem_we;
    w_addr_next  = r_mem_addr;
    w_wdata_next = r_mem_wdata;
    w_sp_dec_en  = 1'b0;
    w_sp_inc_en  = 1'b0;
    w_fault_set  = 1'b0;
    w_capture    = 1'b0;
    w_pop_done   = 1'b0;
    w_flags_load = 1'b0;
    w_reti_done  = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (irqTake) begin
          w_state_next = ST_IRQ_PC;
          w_capture    = 1'b1;
          w_req_next   = !w_refuse_push;
          w_we_next    = !w_refuse_push;
          w_fault_set  = w_refuse_push;
          w_addr_next  = w_sp_dec;
          w_wdata_next = irqPc;
        end else if (reti) begin
          w_state_next = ST_RETI_FL;
          w_req_next   = !w_refuse_pop;
          w_we_next    = 1'b0;
          w_fault_set  = w_refuse_pop;
          w_addr_next  = w_sp;
        end else if (pop) begin
          w_state_next = ST_POP_RD;
          w_req_next   = !w_refuse_pop;
          w_we_next    = 1'b0;
          w_fault_set  = w_refuse_pop;
          w_addr_next  = w_sp;
        end else if (push) begin
          w_state_next = ST_PUSH_WR;
          w_req_next   = !w_refuse_push;
          w_we_next    = !w_refuse_push;
          w_fault_set  = w_refuse_push;
          w_addr_next  = w_sp_dec;
          w_wdata_next = pushData;
        end
      end
      ST_PUSH_WR: begin
        if (w_word_done) begin
          w_sp_dec_en  = r_mem_req;
          w_req_next   = 1'b0;
          w_we_next    = 1'b0;
          w_state_next = ST_IDLE;
        end
      end
      ST_POP_RD: begin
        if (w_word_done) begin
          w_sp_inc_en  = r_mem_req;
          w_pop_done   = 1'b1;
          w_req_next   = 1'b0;
          w_state_next = ST_IDLE;
        end
      end
      ST_IRQ_PC: begin
        if (w_word_done) begin
          w_sp_dec_en  = r_mem_req;
          w_state_next = ST_IRQ_FL;
          w_req_next   = !w_refuse_push2;
          w_we_next    = !w_refuse_push2;
          w_fault_set  = w_refuse_push2;
          w_addr_next  = r_mem_req ? w_sp_dec2 : w_sp_dec;
          w_wdata_next = {{(DATA_W-FLAGS_W){1'b0}}, r_irq_flags};
        end
      end
      ST_IRQ_FL: begin
        if (w_word_done) begin
          w_sp_dec_en  = r_mem_req;
          w_req_next   = 1'b0;
          w_we_next    = 1'b0;
          w_state_next = ST_IDLE;
        end
      end
      ST_RETI_FL: begin
        if (w_word_done) begin
          w_sp_inc_en  = r_mem_req;
          w_flags_load = 1'b1;
          w_state_next = ST_RETI_PC;
          w_req_next   = !w_refuse_pop2;
          w_we_next    = 1'b0;
          w_fault_set  = w_refuse_pop2;
          w_addr_next  = r_mem_req ? w_sp_inc : w_sp;
        end
      end
      ST_RETI_PC: begin
        if (w_word_done) begin
          w_sp_inc_en  = r_mem_req;
          w_reti_done  = 1'b1;
          w_req_next   = 1'b0;
          w_state_next = ST_IDLE;
        end
      end
      default: begin
        w_state_next = ST_IDLE;
        w_req_next   = 1'b0;
        w_we_next    = 1'b0;
      end
    endcase
  end

  // Registered memory port; address and data hold while a request waits
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      r_mem_req   <= 1'b0;
      r_mem_we    <= 1'b0;
      r_mem_addr  <= '0;
      r_mem_wdata <= '0;
    end else begin
      r_mem_req   <= w_req_next;
      r_mem_we    <= w_we_next;
      r_mem_addr  <= w_addr_next;
      r_mem_wdata <= w_wdata_next;
    end
  end

  // Hold interrupt flags from accept until the second frame word issues
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      r_irq_flags <= '0;
    end else if (w_capture) begin
      r_irq_flags <= flagsIn;
    end
  end

  // Result registers: data holds between completions, valids pulse once
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      r_pop_data       <= '0;
      r_pop_valid      <= 1'b0;
      r_reti_flags_tmp <= '0;
      r_reti_pc        <= '0;
      r_reti_flags     <= '0;
      r_reti_valid     <= 1'b0;
    end else begin
      r_pop_valid  <= w_pop_done;
      r_reti_valid <= w_reti_done;
      if (w_pop_done) begin
        r_pop_data <= w_rd_word;
      end
      if (w_flags_load) begin
        r_reti_flags_tmp <= w_rd_word[FLAGS_W-1:0];
      end
      if (w_reti_done) begin
        r_reti_pc    <= w_rd_word;
        r_reti_flags <= r_reti_flags_tmp;
      end
    end
  end

  assign stall     = (r_state != ST_IDLE) | push | pop | reti | irqTake;
  assign memReq    = r_mem_req;
  assign memWe     = r_mem_we;
  assign memAddr   = r_mem_addr;
  assign memWdata  = r_mem_wdata;
  assign popData   = r_pop_data;
  assign popValid  = r_pop_valid;
  assign retiPc    = r_reti_pc;
  assign retiFlags = r_reti_flags;
  assign retiValid = r_reti_valid;
  assign sp        = w_sp;

endmodule

// File: tb/tb_stack_unit.sv
// Directed bench for stack_unit with a behavioural data memory that acks
// after a programmable delay. Bounds vectors follow STACK_BOUNDS_CHECK_EN.
module tb_stack_unit;

  logic        clk = 1'b0;
  logic        resetN;
  logic        push, pop, reti, irqTake;
  logic [31:0] pushData, irqPc;
  logic [3:0]  flagsIn;
  logic        memReq, memWe;
  logic [15:0] memAddr;
  logic [31:0] memWdata;
  logic [31:0] memRdata = 32'h0;
  logic        memAck = 1'b0;
  logic        stall;
  logic [31:0] popData;
  logic        popValid;
  logic [31:0] retiPc;
  logic [3:0]  retiFlags;
  logic        retiValid;
  logic [15:0] sp;
  logic        stackFault;

  int total = 0;
  int bad   = 0;

  logic [31:0] mem [0:16383];
  logic [15:0] wr_addr_q [$];
  logic [31:0] wr_data_q [$];
  int          ack_delay = 0;
  int          ack_cnt   = 0;
  bit          ack_on    = 1'b0;
  int          s0;

  stack_unit dut (
    .clk        (clk),
    .resetN     (resetN),
    .push       (push),
    .pop        (pop),
    .reti       (reti),
    .irqTake    (irqTake),
    .pushData   (pushData),
    .irqPc      (irqPc),
    .flagsIn    (flagsIn),
    .memReq     (memReq),
    .memWe      (memWe),
    .memAddr    (memAddr),
    .memWdata   (memWdata),
    .memRdata   (memRdata),
    .memAck     (memAck),
    .stall      (stall),
    .popData    (popData),
    .popValid   (popValid),
    .retiPc     (retiPc),
    .retiFlags  (retiFlags),
    .retiValid  (retiValid),
    .sp         (sp),
    .stackFault (stackFault)
  );

  always #5 clk = ~clk;

  // Memory responder: acts on the falling edge, ack seen by the next rise
  always @(negedge clk) begin
    if (ack_on) begin
      ack_on  = 1'b0;
      ack_cnt = 0;
    end
    memAck = 1'b0;
    if (resetN && memReq) begin
      if (ack_cnt >= ack_delay) begin
        memAck = 1'b1;
        ack_on = 1'b1;
        if (memWe) begin
          mem[memAddr[15:2]] = memWdata;
          wr_addr_q.push_back(memAddr);
          wr_data_q.push_back(memWdata);
          $display("mem wr addr=%h data=%h", memAddr, memWdata);
        end else begin
          memRdata = mem[memAddr[15:2]];
          $display("mem rd addr=%h data=%h", memAddr, memRdata);
        end
      end else begin
        ack_cnt++;
      end
    end else begin
      ack_cnt = 0;
    end
  end

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Present commands for one accept cycle, then drop them
  task automatic send(input logic p, input logic po, input logic r, input logic irq);
    push = p; pop = po; reti = r; irqTake = irq;
    #1;
    check_val("stall_on_cmd", 32'(stall), 32'h1);
    step();
    push = 1'b0; pop = 1'b0; reti = 1'b0; irqTake = 1'b0;
  endtask

  task automatic wait_idle(input int max_cyc);
    int n;
    n = 0;
    do begin
      step();
      n++;
    end while (stall && n < max_cyc);
    check_val("idle_reached", 32'(stall), 32'h0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < 16384; i++) mem[i] = 32'h0;
    resetN = 1'b0;
    push = 1'b0; pop = 1'b0; reti = 1'b0; irqTake = 1'b0;
    pushData = 32'h0; irqPc = 32'h0; flagsIn = 4'h0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    resetN = 1'b1;
    step();

    // Reset state
    check_val("rst_sp",        32'(sp), 32'hFFFC);
    check_val("rst_memReq",    32'(memReq), 32'h0);
    check_val("rst_memAddr",   32'(memAddr), 32'h0);
    check_val("rst_stall",     32'(stall), 32'h0);
    check_val("rst_popValid",  32'(popValid), 32'h0);
    check_val("rst_fault",     32'(stackFault), 32'h0);
    check_val("rst_popData",   popData, 32'h0);

    // Push with immediate ack
    pushData = 32'hDEADBEEF;
    send(1, 0, 0, 0);
    check_val("push_req",   32'(memReq), 32'h1);
    check_val("push_we",    32'(memWe), 32'h1);
    check_val("push_addr",  32'(memAddr), 32'hFFF8);
    check_val("push_wdata", memWdata, 32'hDEADBEEF);
    check_val("push_sp_early", 32'(sp), 32'hFFFC);
    step();
    check_val("push_stall_done", 32'(stall), 32'h0);
    check_val("push_sp",    32'(sp), 32'hFFF8);
    check_val("push_req_off", 32'(memReq), 32'h0);
    check_val("push_wr_addr", 32'(wr_addr_q[wr_addr_q.size()-1]), 32'hFFF8);

    // Pop it back
    send(0, 1, 0, 0);
    check_val("pop_addr",   32'(memAddr), 32'hFFF8);
    check_val("pop_we",     32'(memWe), 32'h0);
    step();
    check_val("pop_valid",  32'(popValid), 32'h1);
    check_val("pop_data",   popData, 32'hDEADBEEF);
    check_val("pop_sp",     32'(sp), 32'hFFFC);
    step();
    check_val("pop_valid_pulse", 32'(popValid), 32'h0);
    check_val("pop_data_hold", popData, 32'hDEADBEEF);

    // Interrupt entry frame
    irqPc = 32'h100; flagsIn = 4'b1010;
    send(0, 0, 0, 1);
    check_val("irq_addr1",  32'(memAddr), 32'hFFF8);
    check_val("irq_wdata1", memWdata, 32'h100);
    step();
    check_val("irq_sp_mid", 32'(sp), 32'hFFF8);
    check_val("irq_req2",   32'(memReq), 32'h1);
    check_val("irq_addr2",  32'(memAddr), 32'hFFF4);
    check_val("irq_wdata2", memWdata, 32'hA);
    step();
    check_val("irq_stall_done", 32'(stall), 32'h0);
    check_val("irq_sp",     32'(sp), 32'hFFF4);
    check_val("irq_log_a0", 32'(wr_addr_q[wr_addr_q.size()-2]), 32'hFFF8);
    check_val("irq_log_d1", wr_data_q[wr_data_q.size()-1], 32'hA);

    // Return from interrupt
    send(0, 0, 1, 0);
    check_val("reti_addr1", 32'(memAddr), 32'hFFF4);
    check_val("reti_we",    32'(memWe), 32'h0);
    step();
    check_val("reti_addr2", 32'(memAddr), 32'hFFF8);
    check_val("reti_sp_mid", 32'(sp), 32'hFFF8);
    step();
    check_val("reti_valid", 32'(retiValid), 32'h1);
    check_val("reti_flags", 32'(retiFlags), 32'hA);
    check_val("reti_pc",    retiPc, 32'h100);
    check_val("reti_sp",    32'(sp), 32'hFFFC);

    // Delayed ack: port and stall held steady, sp untouched
    ack_delay = 5;
    pushData = 32'h12345678;
    send(1, 0, 0, 0);
    for (int i = 0; i < 5; i++) begin
      check_val("dly_req",   32'(memReq), 32'h1);
      check_val("dly_addr",  32'(memAddr), 32'hFFF8);
      check_val("dly_stall", 32'(stall), 32'h1);
      check_val("dly_sp",    32'(sp), 32'hFFFC);
      step();
    end
    wait_idle(20);
    check_val("dly_sp_after", 32'(sp), 32'hFFF8);
    ack_delay = 0;
    send(0, 1, 0, 0);
    step();
    check_val("dly_pop_data", popData, 32'h12345678);
    check_val("dly_pop_sp",   32'(sp), 32'hFFFC);

    // Simultaneous irq, push and pop: only the irq frame goes out
    s0 = wr_addr_q.size();
    irqPc = 32'h200; flagsIn = 4'b0101; pushData = 32'h77;
    send(1, 1, 0, 1);
    wait_idle(10);
    check_val("prio_nwr",   32'(wr_addr_q.size() - s0), 32'h2);
    check_val("prio_d0",    wr_data_q[s0], 32'h200);
    check_val("prio_d1",    wr_data_q[s0+1], 32'h5);
    check_val("prio_sp",    32'(sp), 32'hFFF4);
    send(0, 0, 1, 0);
    wait_idle(10);
    check_val("prio_reti_pc", retiPc, 32'h200);
    check_val("prio_reti_fl", 32'(retiFlags), 32'h5);
    check_val("prio_reti_sp", 32'(sp), 32'hFFFC);

`ifdef STACK_BOUNDS_CHECK_EN
    // Pop on an empty stack is refused
    send(0, 1, 0, 0);
    check_val("bnd_pop_noreq", 32'(memReq), 32'h0);
    step();
    check_val("bnd_pop_valid", 32'(popValid), 32'h1);
    check_val("bnd_pop_data",  popData, 32'h0);
    check_val("bnd_fault",     32'(stackFault), 32'h1);
    check_val("bnd_pop_sp",    32'(sp), 32'hFFFC);
    // Fill down to the limit, then one more push is refused
    for (int i = 0; i < 1023; i++) begin
      push = 1'b1; pushData = 32'(i);
      step();
      push = 1'b0;
      step();
    end
    check_val("bnd_fill_sp", 32'(sp), 32'hF000);
    s0 = wr_addr_q.size();
    send(1, 0, 0, 0);
    check_val("bnd_push_noreq", 32'(memReq), 32'h0);
    step();
    check_val("bnd_push_nowr", 32'(wr_addr_q.size() - s0), 32'h0);
    check_val("bnd_push_sp",   32'(sp), 32'hF000);
    check_val("bnd_push_idle", 32'(stall), 32'h0);
    resetN = 1'b0;
    #1;
    check_val("bnd_fault_clr", 32'(stackFault), 32'h0);
    @(negedge clk);
    resetN = 1'b1;
    step();
`else
    // No checks: pop on empty wraps the pointer and reads the top word
    send(0, 1, 0, 0);
    step();
    check_val("wrap_pop_valid", 32'(popValid), 32'h1);
    check_val("wrap_pop_data",  popData, 32'h0);
    check_val("wrap_sp",        32'(sp), 32'h0000);
    check_val("wrap_fault",     32'(stackFault), 32'h0);
    pushData = 32'h55;
    send(1, 0, 0, 0);
    check_val("wrap_push_addr", 32'(memAddr), 32'hFFFC);
    step();
    check_val("wrap_push_sp",   32'(sp), 32'hFFFC);
`endif

    // Reset while restoring the PC word
    irqPc = 32'h300; flagsIn = 4'b0011;
    send(0, 0, 0, 1);
    wait_idle(10);
    ack_delay = 3;
    send(0, 0, 1, 0);
    for (int i = 0; i < 20; i++) begin
      if (memReq && memAddr == 16'hFFF8) break;
      step();
    end
    check_val("rst_mid_reached", 32'(memAddr), 32'hFFF8);
    #2;
    resetN = 1'b0;
    #1;
    check_val("rst_mid_sp",      32'(sp), 32'hFFFC);
    check_val("rst_mid_req",     32'(memReq), 32'h0);
    check_val("rst_mid_addr",    32'(memAddr), 32'h0);
    check_val("rst_mid_wdata",   memWdata, 32'h0);
    check_val("rst_mid_stall",   32'(stall), 32'h0);
    check_val("rst_mid_rvalid",  32'(retiValid), 32'h0);
    check_val("rst_mid_retipc",  retiPc, 32'h0);
    check_val("rst_mid_retifl",  32'(retiFlags), 32'h0);
    check_val("rst_mid_popdata", popData, 32'h0);
    ack_delay = 0;
    @(negedge clk);
    resetN = 1'b1;
    step();
    check_val("post_rst_sp",    32'(sp), 32'hFFFC);
    check_val("post_rst_req",   32'(memReq), 32'h0);
    check_val("post_rst_stall", 32'(stall), 32'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
